// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: the PC generator's state encoding, the instruction
// size and the default boot/trap vectors that the IFU and decode stages also use.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int unsigned INST_BYTES = 4;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator feeding the IFU: sequential fetch, redirects, traps and halt.
// All outputs are registered, so every control input shows up one cycle after it is sampled.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned          ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
   parameter logic [ADDR_W-1:0]    TRAP_VECTOR  = ADDR_W'(DEFAULT_TRAP_VECTOR)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              trap_valid,
   input  logic              halt,
   output logic [ADDR_W-1:0] fetch_add,
   output logic              fetch_valid,
   output logic              fetch_epoch,
   output logic              misalign_err,
   output logic [ADDR_W-1:0] misalign_addr
);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              valid_q, valid_d;
   logic              epoch_q, epoch_d;
   logic              merr_q, merr_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         epoch_q <= 1'b0;
         merr_q  <= 1'b0;
         maddr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         epoch_q <= epoch_d;
         merr_q  <= merr_d;
         maddr_q <= maddr_d;
      end
   end

   // Trap beats redirect beats halt beats sequential fetch; trap and redirect work in every state.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      epoch_d = epoch_q;
      merr_d  = 1'b0;
      maddr_d = maddr_q;

      if (trap_valid) begin
         state_d = RUN;
         pc_d    = TRAP_VECTOR;
         valid_d = 1'b1;
         epoch_d = ~epoch_q;
      end else if (redirect_valid) begin
         state_d = RUN;
         valid_d = 1'b1;
         epoch_d = ~epoch_q;
         if (redirect_target[1:0] != 2'b00) begin
            pc_d    = TRAP_VECTOR;
            merr_d  = 1'b1;
            maddr_d = redirect_target;
         end else begin
            pc_d = redirect_target;
         end
      end else begin
         unique case (state_q)
            BOOT: begin
               state_d = RUN;
               valid_d = 1'b1;
            end
            RUN: begin
               if (halt) begin
                  state_d = HALT;
                  valid_d = 1'b0;
               end else if (valid_q && fetch_ready) begin
                  pc_d = pc_q + ADDR_W'(INST_BYTES);
               end
            end
            HALT: begin
               valid_d = 1'b0;
            end
            default: begin
               state_d = BOOT;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   assign fetch_add     = pc_q;
   assign fetch_valid   = valid_q;
   assign fetch_epoch   = epoch_q;
   assign misalign_err  = merr_q;
   assign misalign_addr = maddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed walk through boot, stall, redirect, halt and collisions,
// then randomized traffic, all compared against a flag-and-arithmetic reference model.
module tb_pc_gen;

   logic        clock;
   logic        reset;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_valid;
   logic        halt;
   logic [31:0] fetch_add;
   logic        fetch_valid;
   logic        fetch_epoch;
   logic        misalign_err;
   logic [31:0] misalign_addr;

   int assertCount = 0;
   int failCount   = 0;

   bit          mRunning;
   bit          mHalted;
   logic [31:0] mPc;
   bit          mEpoch;
   bit          mErr;
   logic [31:0] mAddr;

   pc_gen #(
      .ADDR_W       (32),
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_0100)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .fetch_ready     (fetch_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .halt            (halt),
      .fetch_add       (fetch_add),
      .fetch_valid     (fetch_valid),
      .fetch_epoch     (fetch_epoch),
      .misalign_err    (misalign_err),
      .misalign_addr   (misalign_addr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic modelReset();
      mRunning = 0;
      mHalted  = 0;
      mPc      = 32'h0;
      mEpoch   = 0;
      mErr     = 0;
      mAddr    = 32'h0;
   endtask

   // One clock edge of the fetch stage, worked out from the priority rules directly.
   task automatic modelEdge(input bit rdy, input bit redir, input logic [31:0] tgt,
                            input bit trap, input bit hlt);
      mErr = 0;
      if (trap) begin
         mPc      = 32'h100;
         mEpoch   = !mEpoch;
         mRunning = 1;
         mHalted  = 0;
      end else if (redir) begin
         mEpoch   = !mEpoch;
         mRunning = 1;
         mHalted  = 0;
         if ((tgt % 4) != 0) begin
            mPc   = 32'h100;
            mErr  = 1;
            mAddr = tgt;
         end else begin
            mPc = tgt;
         end
      end else if (!mRunning && !mHalted) begin
         mRunning = 1;
      end else if (mRunning && hlt) begin
         mRunning = 0;
         mHalted  = 1;
      end else if (mRunning && rdy) begin
         mPc = mPc + 32'd4;
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string step);
      checkValue({step, " fetch_add"},     fetch_add,             mPc);
      checkValue({step, " fetch_valid"},   {31'b0, fetch_valid},  {31'b0, mRunning});
      checkValue({step, " fetch_epoch"},   {31'b0, fetch_epoch},  {31'b0, mEpoch});
      checkValue({step, " misalign_err"},  {31'b0, misalign_err}, {31'b0, mErr});
      checkValue({step, " misalign_addr"}, misalign_addr,         mAddr);
   endtask

   // Drives one cycle's inputs, lets an edge happen, advances the model, and samples 1 unit later.
   task automatic applyStimulus(input bit rdy, input bit redir, input logic [31:0] tgt,
                                input bit trap, input bit hlt);
      fetch_ready     = rdy;
      redirect_valid  = redir;
      redirect_target = tgt;
      trap_valid      = trap;
      halt            = hlt;
      @(posedge clock);
      modelEdge(rdy, redir, tgt, trap, hlt);
      #1;
   endtask

   initial begin
      logic [31:0] tgt;
      bit          rdy, redir, trap, hlt;

      reset           = 1'b1;
      fetch_ready     = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      trap_valid      = 1'b0;
      halt            = 1'b0;
      modelReset();

      repeat (2) @(posedge clock);
      #1;
      checkValue("reset fetch_add", fetch_add, 32'h0);
      checkValue("reset fetch_valid", {31'b0, fetch_valid}, 32'h0);
      checkOutput("reset");
      reset = 1'b0;

      applyStimulus(1, 0, 0, 0, 0);
      checkValue("boot fetch_add", fetch_add, 32'h0);
      checkValue("boot fetch_valid", {31'b0, fetch_valid}, 32'h1);
      checkOutput("boot");
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("seq 4", fetch_add, 32'h4);
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("seq 8", fetch_add, 32'h8);
      checkOutput("seq");

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkValue("stall hold", fetch_add, 32'h8);
      end
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("stall release", fetch_add, 32'hC);

      applyStimulus(1, 1, 32'h40, 0, 0);
      checkValue("redirect target", fetch_add, 32'h40);
      checkValue("redirect epoch", {31'b0, fetch_epoch}, 32'h1);
      checkOutput("redirect");
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("redirect next", fetch_add, 32'h44);

      applyStimulus(1, 1, 32'h12, 0, 0);
      checkValue("misalign fetch_add", fetch_add, 32'h100);
      checkValue("misalign err", {31'b0, misalign_err}, 32'h1);
      checkValue("misalign addr", misalign_addr, 32'h12);
      checkValue("misalign epoch", {31'b0, fetch_epoch}, 32'h0);
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("misalign pulse end", {31'b0, misalign_err}, 32'h0);
      checkValue("misalign addr held", misalign_addr, 32'h12);
      checkOutput("misalign");

      applyStimulus(1, 1, 32'h20, 0, 0);
      applyStimulus(1, 0, 0, 0, 1);
      checkValue("halt valid", {31'b0, fetch_valid}, 32'h0);
      checkValue("halt fetch_add", fetch_add, 32'h20);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         checkValue("halted frozen", fetch_add, 32'h20);
         checkValue("halted valid", {31'b0, fetch_valid}, 32'h0);
      end
      applyStimulus(1, 0, 0, 1, 0);
      checkValue("trap exits halt", fetch_add, 32'h100);
      checkValue("trap valid", {31'b0, fetch_valid}, 32'h1);
      checkOutput("trap");

      applyStimulus(1, 1, 32'hFFFF_FFFC, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkValue("wrap", fetch_add, 32'h0);

      tgt = {31'b0, fetch_epoch};
      applyStimulus(1, 1, 32'h80, 1, 0);
      checkValue("collision fetch_add", fetch_add, 32'h100);
      checkValue("collision single toggle", {31'b0, fetch_epoch}, {31'b0, ~tgt[0]});
      applyStimulus(1, 1, 32'h81, 1, 0);
      checkValue("collision no misalign", {31'b0, misalign_err}, 32'h0);
      applyStimulus(1, 1, 32'h300, 0, 1);
      checkValue("redirect beats halt", fetch_add, 32'h300);
      checkValue("redirect beats halt valid", {31'b0, fetch_valid}, 32'h1);
      checkOutput("collision");

      for (int i = 0; i < 400; i++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 7) == 0);
         trap  = ($urandom_range(0, 15) == 0);
         hlt   = ($urandom_range(0, 7) == 0);
         tgt   = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         applyStimulus(rdy, redir, tgt, trap, hlt);
         checkOutput("random");
      end

      applyStimulus(1, 1, 32'h40, 0, 0);
      fetch_ready     = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkValue("async reset fetch_add", fetch_add, 32'h0);
      checkOutput("async reset");
      @(posedge clock);
      #1;
      checkOutput("reset held");
      reset          = 1'b0;
      redirect_valid = 1'b0;

      for (int i = 0; i < 100; i++) begin
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 7) == 0);
         trap  = ($urandom_range(0, 15) == 0);
         hlt   = ($urandom_range(0, 7) == 0);
         tgt   = $urandom();
         applyStimulus(rdy, redir, tgt, trap, hlt);
         checkOutput("random2");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
